// File: rtl/sseg_time_mux.sv
// Four-digit seven-segment time multiplexer with per-slot blanking gap
// and a frame-synchronous double buffer for the displayed patterns.
module sseg_time_mux #(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] en_mask,
  input  logic       load,
  output logic       busy,
  output logic       frame_tick,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] BLK  = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic [3:0][7:0]  r_shadow;
  logic [3:0]       r_smask;
  logic [3:0][7:0]  r_pend;
  logic [3:0]       r_pmask;
  logic             r_busy;
  logic             r_tick;
  logic [3:0]       r_an;
  logic [7:0]       r_sseg;

  logic             w_wrap;
  logic             w_bound;
  logic             w_lit;
  logic [3:0]       w_an_nx;
  logic [7:0]       w_sseg_nx;
  logic [3:0][7:0]  w_in;

  always_comb begin
    w_in      = {in3, in2, in1, in0};
    w_wrap    = (r_cnt == LAST);
    w_bound   = w_wrap && (r_sel == 2'd3);
    w_lit     = (r_cnt >= BLK) && r_smask[r_sel];
    w_an_nx   = 4'b1111;
    w_sseg_nx = 8'hFF;
    if (w_lit) begin
      w_an_nx   = ~(4'b0001 << r_sel);
      w_sseg_nx = r_shadow[r_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_sel    <= 2'd0;
      r_shadow <= {4{8'hFF}};
      r_smask  <= 4'b0000;
      r_pend   <= {4{8'hFF}};
      r_pmask  <= 4'b0000;
      r_busy   <= 1'b0;
      r_tick   <= 1'b0;
      r_an     <= 4'b1111;
      r_sseg   <= 8'hFF;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_sel  <= w_wrap ? r_sel + 2'd1 : r_sel;
      r_tick <= w_bound;
      r_an   <= w_an_nx;
      r_sseg <= w_sseg_nx;
      // A load landing on the boundary skips the pending stage entirely.
      if (w_bound) begin
        if (load) begin
          r_shadow <= w_in;
          r_smask  <= en_mask;
        end else if (r_busy) begin
          r_shadow <= r_pend;
          r_smask  <= r_pmask;
        end
        r_busy <= 1'b0;
      end else if (load) begin
        r_pend  <= w_in;
        r_pmask <= en_mask;
        r_busy  <= 1'b1;
      end
    end
  end

  assign busy       = r_busy;
  assign frame_tick = r_tick;
  assign an         = r_an;
  assign sseg       = r_sseg;

endmodule

// File: tb/tb_sseg_time_mux.sv
// Randomised bench for sseg_time_mux against a frame-position model
// (DIGIT_CYC=8, BLANK_CYC=2).
module tb_sseg_time_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] en_mask;
  logic       load;
  logic       busy, frame_tick;
  logic [3:0] an;
  logic [7:0] sseg;

  sseg_time_mux #(
    .DIGIT_CYC(8),
    .BLANK_CYC(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .en_mask(en_mask),
    .load(load),
    .busy(busy),
    .frame_tick(frame_tick),
    .an(an),
    .sseg(sseg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int g_cyc = 0;

  // model: position of the current cycle inside a 32-clock frame
  int         m_pos;
  logic [7:0] m_sh [4];
  logic [3:0] m_sm;
  logic [7:0] m_pd [4];
  logic [3:0] m_pm;
  logic       m_busy;
  logic [3:0] e_an;
  logic [7:0] e_sseg;
  logic       e_tick;
  logic [13:0] e_all;
  logic [13:0] o_all;

  task automatic cyc(input logic rst, input logic ld);
    int slot, off;
    @(negedge clk);
    reset = rst;
    load  = ld;
    @(posedge clk);
    g_cyc++;
    if (rst) begin
      m_pos = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
      m_sm   = 4'b0000;
      m_busy = 1'b0;
      e_an   = 4'b1111;
      e_sseg = 8'hFF;
      e_tick = 1'b0;
    end else begin
      slot = m_pos / 8;
      off  = m_pos % 8;
      e_an   = 4'b1111;
      e_sseg = 8'hFF;
      if (off >= 2 && m_sm[slot]) begin
        e_an = 4'b1111;
        e_an[slot] = 1'b0;
        e_sseg = m_sh[slot];
      end
      e_tick = (m_pos == 31);
      if (m_pos == 31) begin
        if (ld) begin
          m_sh = '{in0, in1, in2, in3};
          m_sm = en_mask;
        end else if (m_busy) begin
          m_sh = m_pd;
          m_sm = m_pm;
        end
        m_busy = 1'b0;
      end else if (ld) begin
        m_pd   = '{in0, in1, in2, in3};
        m_pm   = en_mask;
        m_busy = 1'b1;
      end
      m_pos = (m_pos + 1) % 32;
    end
    #1;
    e_all = {e_an, e_sseg, m_busy, e_tick};
    o_all = {an, sseg, busy, frame_tick};
  endtask

  task automatic set_in(input logic [7:0] a, b, c, d,
                        input logic [3:0] m);
    in0 = a; in1 = b; in2 = c; in3 = d; en_mask = m;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      n_chk++;
      if (o_all !== 14'h3FFC) begin
        n_fail++;
        $display("FAIL reset: got %h want %h", o_all, 14'h3FFC);
      end
    end
  endtask

  task automatic test_dark;
    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (o_all !== e_all || an !== 4'b1111) begin
        n_fail++;
        $display("FAIL dark c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_commit;
    set_in(8'hC0, 8'hF9, 8'hA4, 8'hB0, 4'hF);
    while (m_pos != 5) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (o_all !== e_all) begin
        n_fail++;
        $display("FAIL commit c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_last_wins;
    set_in(8'h99, 8'hF9, 8'hA4, 8'hB0, 4'hF);
    while (m_pos != 3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    in0 = 8'h92;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (o_all !== e_all || sseg === 8'h99) begin
        n_fail++;
        $display("FAIL last_wins c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_boundary_load;
    set_in(8'h80, 8'h11, 8'h22, 8'h33, 4'b0101);
    while (m_pos != 31) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    n_chk++;
    if (busy !== 1'b0 || frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL bnd_load: busy=%b tick=%b want 0 1", busy, frame_tick);
    end
    for (int i = 0; i < 33; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (o_all !== e_all || an[1] !== 1'b1 || an[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL bnd_frame c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_reset_mid;
    set_in(8'h55, 8'h66, 8'h77, 8'h88, 4'hF);
    while (m_pos != 10) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    while (m_pos != 20) cyc(1'b0, 1'b0);
    n_chk++;
    if (busy !== 1'b1 || an !== 4'b1011) begin
      n_fail++;
      $display("FAIL pre_rst: busy=%b an=%b want 1 1011", busy, an);
    end
    cyc(1'b1, 1'b0);
    n_chk++;
    if (o_all !== 14'h3FFC) begin
      n_fail++;
      $display("FAIL mid_rst: got %h want %h", o_all, 14'h3FFC);
    end
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0);
      n_chk++;
      if (o_all !== e_all || an !== 4'b1111) begin
        n_fail++;
        $display("FAIL post_rst c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      set_in(8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 4'($urandom));
      cyc(1'b0, 1'b1);
      n_chk++;
      if (o_all !== e_all) begin
        n_fail++;
        $display("FAIL b2b c%0d: got %h want %h", i, o_all, e_all);
      end
    end
  endtask

  task automatic test_random;
    int last = -1;
    logic ld;
    for (int i = 0; i < 800; i++) begin
      ld = ($urandom_range(0, 19) == 0);
      if (ld) set_in(8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 4'($urandom));
      cyc(1'b0, ld);
      n_chk++;
      if (o_all !== e_all) begin
        n_fail++;
        $display("FAIL rand c%0d: got %h want %h", i, o_all, e_all);
      end
      if (frame_tick === 1'b1) begin
        if (last >= 0) begin
          n_chk++;
          if (g_cyc - last !== 32) begin
            n_fail++;
            $display("FAIL tick_period: got %0d want 32", g_cyc - last);
          end
        end
        last = g_cyc;
      end
    end
    n_chk++;
    if (last < 0) begin
      n_fail++;
      $display("FAIL tick_seen: got none want pulses");
    end
  endtask

  initial begin
    reset = 1'b1;
    load  = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
    test_reset;
    test_dark;
    test_commit;
    test_last_wins;
    test_boundary_load;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
